// File: rtl/grid_sequencer_pkg.sv
// Shared types and constants for the systolic grid sequencer.
package grid_sequencer_pkg;

  localparam int GS_N            = 4;
  localparam int GS_DATA_WIDTH   = 8;
  localparam int GS_RESULT_WIDTH = 32;
  localparam int GS_ROWS_W       = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } state_e;

  // Number of advancing cycles from accepting an activation vector to the
  // aligned result appearing at the output.
  function automatic int lat(input int n);
    return 2 * n - 1;
  endfunction

endpackage

// File: rtl/grid_sequencer_if.sv
// Host-side command / input / result handshake bundle of the grid sequencer.
interface grid_sequencer_if
  import grid_sequencer_pkg::*;
#(
  parameter int N            = GS_N,
  parameter int DATA_WIDTH   = GS_DATA_WIDTH,
  parameter int RESULT_WIDTH = GS_RESULT_WIDTH,
  parameter int ROWS_W       = GS_ROWS_W
);
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic                      cmd_load_w;
  logic [ROWS_W-1:0]         cmd_rows;
  logic                      in_valid;
  logic                      in_ready;
  logic [N*DATA_WIDTH-1:0]   in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [N*RESULT_WIDTH-1:0] out_data;
  logic                      out_last;

  modport master (
    output cmd_valid, cmd_load_w, cmd_rows, in_valid, in_data, out_ready,
    input  cmd_ready, in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  cmd_valid, cmd_load_w, cmd_rows, in_valid, in_data, out_ready,
    output cmd_ready, in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/grid_sequencer_delay_line.sv
// Enable-gated shift register; DEPTH of zero degenerates to a plain wire.
module delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1,
  parameter bit EN    = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  if (DEPTH == 0) begin : g_wire
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, reset, en};
    assign dout = din;
  end else begin : g_regs
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    // Shift one position per enabled cycle, otherwise hold.
    always_comb begin
      for (int k = 0; k < DEPTH; k++) stage_d[k] = stage_q[k];
      if (!EN || en) begin
        stage_d[0] = din;
        for (int k = 1; k < DEPTH; k++) stage_d[k] = stage_q[k-1];
      end
    end

    // Stage registers, cleared on reset.
    always_ff @(posedge clk) begin
      if (reset) stage_q <= '{default: '0};
      else       stage_q <= stage_d;
    end

    assign dout = stage_q[DEPTH-1];
  end
endmodule

// File: rtl/grid_sequencer.sv
// Sequencer in front of an NxN weight-stationary systolic grid: loads
// weights, streams skewed activations, de-skews column sums into results.
//
//   state  | meaning
//   IDLE   | waiting for a command, result pipeline empty
//   LOAD_W | passing N weight beats straight to the grid
//   STREAM | pushing activations (or bubbles) into the skew line
//   DRAIN  | pushing bubbles until every tagged result has left
module grid_sequencer
  import grid_sequencer_pkg::*;
#(
  parameter int N            = GS_N,
  parameter int DATA_WIDTH   = GS_DATA_WIDTH,
  parameter int RESULT_WIDTH = GS_RESULT_WIDTH,
  parameter int ROWS_W       = GS_ROWS_W
) (
  input  logic                      clk,
  input  logic                      reset,
  grid_sequencer_if.slave           bus,
  output logic                      busy,
  output logic                      grid_enable,
  output logic                      grid_load_weight,
  output logic [N*DATA_WIDTH-1:0]   grid_inputs_left,
  input  logic [N*RESULT_WIDTH-1:0] grid_sums_bottom
);
  localparam int L      = lat(N);
  localparam int WCNT_W = (N > 1) ? $clog2(N) : 1;

  state_e            state_q, state_d;
  logic [ROWS_W-1:0] rem_q, rem_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [L-1:0]      tv_q, tv_d;   // valid tag per pipeline slot
  logic [L-1:0]      tl_q, tl_d;   // last-of-command tag per slot

  logic stall, adv, pipe_en, accept, push_v, push_l;
  logic cmd_rdy, in_rdy, tags_empty;
  logic [N*DATA_WIDTH-1:0]   skew_in, skew_out;
  logic [N*RESULT_WIDTH-1:0] deskew_out;

  assign stall      = tv_q[L-1] & ~bus.out_ready;
  assign adv        = ~stall;
  assign tags_empty = ~|tv_q;

  // Next-state, counters and handshake/grid control.
  always_comb begin
    state_d          = state_q;
    rem_d            = rem_q;
    wcnt_d           = wcnt_q;
    cmd_rdy          = 1'b0;
    in_rdy           = 1'b0;
    grid_enable      = 1'b0;
    grid_load_weight = 1'b0;
    pipe_en          = 1'b0;
    accept           = 1'b0;
    push_v           = 1'b0;
    push_l           = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_rdy = tags_empty;
        if (bus.cmd_valid && tags_empty) begin
          rem_d  = bus.cmd_rows;
          wcnt_d = WCNT_W'(N - 1);
          if (bus.cmd_load_w)           state_d = LOAD_W;
          else if (bus.cmd_rows != '0)  state_d = STREAM;
        end
      end
      LOAD_W: begin
        in_rdy = 1'b1;
        if (bus.in_valid) begin
          grid_load_weight = 1'b1;
          grid_enable      = 1'b1;
          if (wcnt_q == '0) state_d = (rem_q == '0) ? DRAIN : STREAM;
          else              wcnt_d  = wcnt_q - 1'b1;
        end
      end
      STREAM: begin
        in_rdy      = adv;
        grid_enable = adv;
        pipe_en     = adv;
        accept      = bus.in_valid & adv;
        push_v      = accept;
        push_l      = accept && (rem_q == ROWS_W'(1));
        if (accept) begin
          rem_d = rem_q - 1'b1;
          if (rem_q == ROWS_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        grid_enable = adv;
        pipe_en     = adv;
        if (tags_empty) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Tag pipeline shifts in lockstep with the skew/de-skew lines.
  always_comb begin
    tv_d = tv_q;
    tl_d = tl_q;
    if (pipe_en) begin
      tv_d = {tv_q[L-2:0], push_v};
      tl_d = {tl_q[L-2:0], push_l};
    end
  end

  // State, counters and tag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      wcnt_q  <= '0;
      tv_q    <= '0;
      tl_q    <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      wcnt_q  <= wcnt_d;
      tv_q    <= tv_d;
      tl_q    <= tl_d;
    end
  end

  // Bubbles enter the skew line as zeros so they contribute nothing.
  assign skew_in = accept ? bus.in_data : '0;

  for (genvar i = 0; i < N; i++) begin : g_skew
    delay_line #(.WIDTH(DATA_WIDTH), .DEPTH(i), .EN(1'b1)) u_skew (
      .clk   (clk),
      .reset (reset),
      .en    (pipe_en),
      .din   (skew_in[i*DATA_WIDTH +: DATA_WIDTH]),
      .dout  (skew_out[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  for (genvar j = 0; j < N; j++) begin : g_deskew
    delay_line #(.WIDTH(RESULT_WIDTH), .DEPTH(N - 1 - j), .EN(1'b1)) u_deskew (
      .clk   (clk),
      .reset (reset),
      .en    (pipe_en),
      .din   (grid_sums_bottom[j*RESULT_WIDTH +: RESULT_WIDTH]),
      .dout  (deskew_out[j*RESULT_WIDTH +: RESULT_WIDTH])
    );
  end

  // Weights bypass the skew line; they are fed to every row in the same cycle.
  assign grid_inputs_left = (state_q == LOAD_W) ? bus.in_data : skew_out;

  assign busy          = (state_q != IDLE);
  assign bus.cmd_ready = cmd_rdy;
  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = tv_q[L-1];
  assign bus.out_last  = tv_q[L-1] & tl_q[L-1];
  // Gated so that untagged sums never leak out and reset reads as zero.
  assign bus.out_data  = tv_q[L-1] ? deskew_out : '0;
endmodule

// File: tb/tb_grid_sequencer.sv
// Bench for grid_sequencer: behavioural systolic grid, integer-matmul
// reference model and directed/randomized command sequences.
module tb_grid_sequencer;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int RW = 32;
  localparam int RB = 16;

  typedef logic [N*DW-1:0] vec_t;
  typedef logic [N*RW-1:0] res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, grid_enable, grid_load_weight;
  logic [N*DW-1:0] grid_inputs_left;
  logic [N*RW-1:0] grid_sums_bottom;

  grid_sequencer_if #(.N(N), .DATA_WIDTH(DW), .RESULT_WIDTH(RW), .ROWS_W(RB)) bus ();

  grid_sequencer #(.N(N), .DATA_WIDTH(DW), .RESULT_WIDTH(RW), .ROWS_W(RB)) dut (
    .clk              (clk),
    .reset            (rst),
    .bus              (bus),
    .busy             (busy),
    .grid_enable      (grid_enable),
    .grid_load_weight (grid_load_weight),
    .grid_inputs_left (grid_inputs_left),
    .grid_sums_bottom (grid_sums_bottom)
  );

  always #5 clk = ~clk;

  // Behavioural weight-stationary grid: activations move right, sums move down.
  logic [DW-1:0] gw [N][N];
  logic [DW-1:0] ga [N][N];
  logic [RW-1:0] gp [N][N];

  always @(posedge clk) begin
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        if (rst) begin
          gw[i][j] <= '0; ga[i][j] <= '0; gp[i][j] <= '0;
        end else if (grid_enable && grid_load_weight) begin
          gw[i][j] <= (j == 0) ? grid_inputs_left[i*DW +: DW] : gw[i][j-1];
        end else if (grid_enable) begin
          ga[i][j] <= (j == 0) ? grid_inputs_left[i*DW +: DW] : ga[i][j-1];
          gp[i][j] <= ((i == 0) ? 32'd0 : gp[i-1][j]) +
                      32'(gw[i][j]) * 32'((j == 0) ? grid_inputs_left[i*DW +: DW] : ga[i][j-1]);
        end
      end
  end

  always_comb begin
    grid_sums_bottom = '0;
    for (int j = 0; j < N; j++) grid_sums_bottom[j*RW +: RW] = gp[N-1][j];
  end

  // Cycle counter and passive monitor.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  res_t got_d[$];
  logic got_l[$];
  int   acc_q[$];
  int   ov_q[$];
  int   glw_cycles = 0;
  int   glw_bad = 0;

  always begin
    @(negedge clk);
    #2;
    if (!rst) begin
      if (bus.in_valid && bus.in_ready) acc_q.push_back(cyc);
      if (bus.out_valid) ov_q.push_back(cyc);
      if (bus.out_valid && bus.out_ready) begin
        got_d.push_back(bus.out_data);
        got_l.push_back(bus.out_last);
      end
      if (grid_load_weight) glw_cycles++;
      if (grid_load_weight && !(bus.in_valid && bus.in_ready)) glw_bad++;
    end
  end

  // Result consumer: 0 = always ready, 1 = random, 2 = held off.
  int rdy_mode = 0;
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  int n_total = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
  endtask

  // Reference model state: current weight matrix W[row][col] and vectors.
  logic [DW-1:0] w_mat [N][N];
  vec_t vq[$];
  res_t exp_q[$];

  function automatic res_t ref_mul(input vec_t x);
    res_t r = '0;
    for (int j = 0; j < N; j++) begin
      longint s = 0;
      for (int i = 0; i < N; i++) s += longint'(x[i*DW +: DW]) * longint'(w_mat[i][j]);
      r[j*RW +: RW] = 32'(s);
    end
    return r;
  endfunction

  function automatic int first_ge(input int q[$], input int arm);
    foreach (q[k]) if (q[k] >= arm) return q[k];
    return -1000;
  endfunction

  function automatic int gap_of(input int mode);
    return (mode == 2) ? int'($urandom_range(0, 2)) : mode;
  endfunction

  task automatic rand_weights();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) w_mat[i][j] = 8'($urandom_range(0, 255));
  endtask

  task automatic rand_vecs(input int rows);
    vq.delete();
    for (int r = 0; r < rows; r++) vq.push_back(vec_t'($urandom));
  endtask

  task automatic send_cmd(input bit lw, input int rows, input string nm);
    bit done = 1'b0;
    bus.cmd_valid = 1'b1; bus.cmd_load_w = lw; bus.cmd_rows = RB'(rows);
    for (int k = 0; k < 200 && !done; k++) begin
      #1; done = bus.cmd_ready;
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0; bus.cmd_load_w = 1'b0; bus.cmd_rows = '0;
    chk({nm, "_cmd_accept"}, done, 1);
  endtask

  task automatic send_beat(input vec_t d, input int gap, input string nm);
    bit done = 1'b0;
    for (int g = 0; g < gap; g++) @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = d;
    for (int k = 0; k < 300 && !done; k++) begin
      #1; done = bus.in_ready;
      @(negedge clk);
    end
    bus.in_valid = 1'b0; bus.in_data = '0;
    chk({nm, "_beat_accept"}, done, 1);
  endtask

  // Beat k carries grid column N-1-k, since earlier beats shift further right.
  task automatic send_weights(input int gmode, input string nm);
    for (int k = 0; k < N; k++) begin
      vec_t b = '0;
      for (int i = 0; i < N; i++) b[i*DW +: DW] = w_mat[i][N-1-k];
      send_beat(b, gap_of(gmode), nm);
    end
  endtask

  task automatic wait_idle(input string nm);
    bit ok = 1'b0;
    for (int k = 0; k < 600 && !ok; k++) begin
      @(negedge clk); #1;
      ok = !busy;
    end
    chk({nm, "_idle"}, ok, 1);
  endtask

  task automatic compare(input string nm);
    chk({nm, "_count"}, got_d.size(), exp_q.size());
    for (int k = 0; k < got_d.size() && k < exp_q.size(); k++) begin
      chk($sformatf("%s_data%0d", nm, k), got_d[k], exp_q[k]);
      chk($sformatf("%s_last%0d", nm, k), got_l[k], (k == exp_q.size() - 1));
    end
  endtask

  task automatic run_cmd(input bit lw, input int gmode, input string nm, output int lat_o);
    int arm;
    got_d.delete(); got_l.delete(); exp_q.delete();
    foreach (vq[r]) exp_q.push_back(ref_mul(vq[r]));
    send_cmd(lw, vq.size(), nm);
    if (lw) send_weights(gmode, nm);
    arm = cyc;
    foreach (vq[r]) send_beat(vq[r], gap_of(gmode), nm);
    wait_idle(nm);
    lat_o = first_ge(ov_q, arm) - first_ge(acc_q, arm);
    compare(nm);
  endtask

  initial begin
    int lat_v;
    int g0, b0;
    bus.cmd_valid = 1'b0; bus.cmd_load_w = 1'b0; bus.cmd_rows = '0;
    bus.in_valid = 1'b0; bus.in_data = '0;

    // Reset values over three cycles.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      chk("reset_ctrl", {bus.cmd_ready, bus.in_ready, bus.out_valid, bus.out_last,
                         busy, grid_enable, grid_load_weight}, 7'b1000000);
      chk("reset_out_data", bus.out_data, '0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Identity weights, three known vectors, latency check.
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) w_mat[i][j] = (i == j) ? 8'd1 : 8'd0;
    vq.delete();
    vq.push_back({8'd4, 8'd3, 8'd2, 8'd1});
    vq.push_back({8'd8, 8'd7, 8'd6, 8'd5});
    vq.push_back({8'd12, 8'd11, 8'd10, 8'd9});
    run_cmd(1'b1, 0, "ident", lat_v);
    chk("ident_latency", lat_v, 7);
    chk("ident_vec0", got_d.size() > 0 ? got_d[0] : '0,
        {32'd4, 32'd3, 32'd2, 32'd1});

    // Weights persist across a command without a load.
    rand_vecs(2);
    run_cmd(1'b0, 0, "reuse", lat_v);

    // Every-other-cycle input gaps create bubbles.
    rand_weights(); rand_vecs(3);
    run_cmd(1'b1, 1, "gaps", lat_v);

    // Hold off results mid-stream.
    rand_weights(); rand_vecs(12);
    got_d.delete(); got_l.delete(); exp_q.delete();
    foreach (vq[r]) exp_q.push_back(ref_mul(vq[r]));
    send_cmd(1'b1, 12, "stall");
    send_weights(0, "stall");
    fork
      begin
        foreach (vq[r]) send_beat(vq[r], 0, "stall");
      end
      begin
        bit seen = 1'b0;
        res_t held;
        for (int k = 0; k < 100 && !seen; k++) begin
          @(negedge clk); #1; seen = bus.out_valid;
        end
        chk("stall_first_valid", seen, 1);
        rdy_mode = 2;
        @(negedge clk); #1;
        held = bus.out_data;
        chk("stall_enable", grid_enable, 0);
        for (int c = 0; c < 4; c++) begin
          @(negedge clk); #1;
          chk("stall_enable", grid_enable, 0);
          chk("stall_valid", bus.out_valid, 1);
          chk("stall_in_ready", bus.in_ready, 0);
          chk("stall_data_stable", bus.out_data, held);
        end
        rdy_mode = 0;
      end
    join
    wait_idle("stall");
    compare("stall");

    // Weight-only command: exactly N load cycles, no results.
    rand_weights(); vq.delete();
    g0 = glw_cycles; b0 = glw_bad;
    run_cmd(1'b1, 2, "rows0", lat_v);
    chk("rows0_load_cycles", glw_cycles - g0, N);
    chk("rows0_load_unaccepted", glw_bad - b0, 0);

    // Reset in the middle of a stream.
    rand_weights(); rand_vecs(5);
    send_cmd(1'b1, 5, "abort");
    send_weights(0, "abort");
    send_beat(vq[0], 0, "abort");
    send_beat(vq[1], 0, "abort");
    rst = 1'b1;
    @(negedge clk); #1;
    chk("abort_ctrl", {bus.out_valid, busy, bus.cmd_ready, grid_enable}, 4'b0010);
    rst = 1'b0;
    @(negedge clk);
    rdy_mode = 1;
    rand_weights(); rand_vecs(4);
    run_cmd(1'b1, 2, "after_abort", lat_v);

    // Randomized commands with random back-pressure and gaps.
    for (int it = 0; it < 3; it++) begin
      bit lw = (it == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (lw) rand_weights();
      rand_vecs($urandom_range(1, 6));
      run_cmd(lw, 2, $sformatf("rand%0d", it), lat_v);
    end
    rdy_mode = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
